// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU: single-cycle logic/arith, iterative one-bit-per-cycle shifts
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             zero,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;
    logic [1:0]       sh_op;
    logic [SHW-1:0]   amt;
    logic             is_shift;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] imm_z;
    logic             imm_c;
    logic             imm_err;
    logic [WIDTH-1:0] acc_next;
    logic             acc_out;

    assign amt      = b[SHW-1:0];
    assign is_shift = (op[3:2] == 2'b10);
    assign sum      = {1'b0, a} + {1'b0, b};
    assign diff     = {1'b0, a} - {1'b0, b};

    // Results that are known at the accept edge; a zero-length shift passes a through.
    always_comb begin
        imm_z   = '0;
        imm_c   = 1'b0;
        imm_err = 1'b0;
        case (op)
            4'd0: imm_z = a & b;
            4'd1: imm_z = a | b;
            4'd2: imm_z = ~(a & b);
            4'd3: imm_z = ~(a | b);
            4'd4: imm_z = a ^ b;
            4'd5: imm_z = ~(a ^ b);
            4'd6: begin
                imm_z = sum[WIDTH-1:0];
                imm_c = sum[WIDTH];
            end
            4'd7: begin
                imm_z = diff[WIDTH-1:0];
                imm_c = diff[WIDTH];
            end
            4'd8, 4'd9, 4'd10, 4'd11: imm_z = a;
            default: imm_err = 1'b1;
        endcase
    end

    // One-bit step of the iterative shifter; sh_op is op[1:0] of SHL/SHR/SAR/ROL.
    always_comb begin
        acc_next = acc;
        acc_out  = 1'b0;
        case (sh_op)
            2'd0: begin
                acc_next = {acc[WIDTH-2:0], 1'b0};
                acc_out  = acc[WIDTH-1];
            end
            2'd1: begin
                acc_next = {1'b0, acc[WIDTH-1:1]};
                acc_out  = acc[0];
            end
            2'd2: begin
                acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
                acc_out  = acc[0];
            end
            default: begin
                acc_next = {acc[WIDTH-2:0], acc[WIDTH-1]};
                acc_out  = acc[WIDTH-1];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sh_op     <= '0;
            z         <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (is_shift && amt != '0) begin
                            state <= BUSY;
                            acc   <= a;
                            cnt   <= amt;
                            sh_op <= op[1:0];
                            err   <= 1'b0;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            z         <= imm_z;
                            carry     <= imm_c;
                            zero      <= (imm_z == '0);
                            err       <= imm_err;
                        end
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    carry <= acc_out;
                    cnt   <= cnt - 1'b1;
                    if (cnt == SHW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        z         <= acc_next;
                        zero      <= (acc_next == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed vectors checked against a behavioural ALU model every valid cycle
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] op = 4'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] z;
    logic       carry, zero, err;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [3:0]  op16 = 4'd0;
    logic [15:0] a16 = 16'd0;
    logic [15:0] b16 = 16'd0;
    logic        out_valid16;
    logic        out_ready16 = 1'b1;
    logic [15:0] z16;
    logic        carry16, zero16, err16;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .carry(carry), .zero(zero), .err(err)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .op(op16), .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
        .z(z16), .carry(carry16), .zero(zero16), .err(err16)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic       c;
        logic [7:0] z;
    } res_t;

    typedef struct {
        res_t r;
        int   lat;
        int   acc;
    } txn_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   chk_rdy = 1'b0;
    txn_t q[$];
    bit   head_seen = 1'b0;
    int   head_vcnt = 0;
    res_t last_r;
    logic last_zero;
    int   last_lat = -1;
    int   last_vcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Specification-level model: plain arithmetic on the whole operand.
    function automatic res_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        res_t r;
        int n;
        logic signed [7:0] sx;
        logic [8:0] s;
        n = y % 8;
        sx = x;
        r = '0;
        case (o)
            4'd0: r.z = x & y;
            4'd1: r.z = x | y;
            4'd2: r.z = ~(x & y);
            4'd3: r.z = ~(x | y);
            4'd4: r.z = x ^ y;
            4'd5: r.z = ~(x ^ y);
            4'd6: begin s = x + y; r.z = s[7:0]; r.c = (s > 9'd255); end
            4'd7: begin r.z = x - y; r.c = (x < y); end
            4'd8: begin r.z = x << n; r.c = (n != 0) ? x[8-n] : 1'b0; end
            4'd9: begin r.z = x >> n; r.c = (n != 0) ? x[n-1] : 1'b0; end
            4'd10: begin r.z = sx >>> n; r.c = (n != 0) ? x[n-1] : 1'b0; end
            4'd11: begin r.z = (x << n) | (x >> (8 - n)); r.c = (n != 0) ? x[8-n] : 1'b0; end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [3:0] o, input logic [7:0] y);
        int n;
        n = y % 8;
        return (o >= 4'd8 && o <= 4'd11 && n != 0) ? n + 1 : 1;
    endfunction

    // Compare process: every negedge with reset released.
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_rdy)
                chk("in_ready", in_ready, (q.size() == 0) || (cyc <= q[0].acc));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("stale_out_valid", out_valid, 0);
                end else begin
                    if (!head_seen) begin
                        head_seen = 1'b1;
                        last_lat  = cyc - q[0].acc;
                        chk("latency", last_lat, q[0].lat);
                    end
                    chk("z", z, q[0].r.z);
                    chk("carry", carry, q[0].r.c);
                    chk("zero", zero, q[0].r.z == 8'd0);
                    chk("err", err, q[0].r.err);
                    if (out_ready) begin
                        last_r    = '{err: err, c: carry, z: z};
                        last_zero = zero;
                        last_vcnt = head_vcnt + 1;
                        head_seen = 1'b0;
                        head_vcnt = 0;
                        void'(q.pop_front());
                    end else begin
                        head_vcnt++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        int t = 0;
        txn_t tx;
        @(posedge clk); #1;
        op = o; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        tx.r   = model(o, x, y);
        tx.lat = model_lat(o, y);
        tx.acc = cyc;
        q.push_back(tx);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q.size() != 0 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
            head_seen = 1'b0;
            head_vcnt = 0;
        end
    endtask

    typedef struct {
        logic [3:0] o;
        logic [7:0] x, y, ez;
        logic       ec, ezero, eerr;
        int         elat;
    } vec_t;

    vec_t vecs[14] = '{
        '{4'd2,  8'h12, 8'h45, 8'hFF, 1'b0, 1'b0, 1'b0, 1},
        '{4'd6,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1},
        '{4'd7,  8'h12, 8'h45, 8'hCD, 1'b1, 1'b0, 1'b0, 1},
        '{4'd7,  8'h45, 8'h12, 8'h33, 1'b0, 1'b0, 1'b0, 1},
        '{4'd8,  8'h96, 8'h03, 8'hB0, 1'b0, 1'b0, 1'b0, 4},
        '{4'd10, 8'h92, 8'h02, 8'hE4, 1'b1, 1'b0, 1'b0, 3},
        '{4'd11, 8'h81, 8'h01, 8'h03, 1'b1, 1'b0, 1'b0, 2},
        '{4'd9,  8'h5A, 8'h08, 8'h5A, 1'b0, 1'b0, 1'b0, 1},
        '{4'hE,  8'h33, 8'h44, 8'h00, 1'b0, 1'b1, 1'b1, 1},
        '{4'd0,  8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 1},
        '{4'd1,  8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0, 1},
        '{4'd3,  8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1},
        '{4'd9,  8'h81, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 8},
        '{4'd10, 8'h80, 8'hF7, 8'hFF, 1'b0, 1'b0, 1'b0, 8}
    };

    task automatic run_vec(input int i);
        res_t m;
        m = model(vecs[i].o, vecs[i].x, vecs[i].y);
        chk("model_z", m.z, vecs[i].ez);
        chk("model_carry", m.c, vecs[i].ec);
        send(vecs[i].o, vecs[i].x, vecs[i].y);
        wait_drain();
        chk("lit_z", last_r.z, vecs[i].ez);
        chk("lit_carry", last_r.c, vecs[i].ec);
        chk("lit_zero", last_zero, vecs[i].ezero);
        chk("lit_err", last_r.err, vecs[i].eerr);
        chk("lit_latency", last_lat, vecs[i].elat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_z", z, 0);
        chk("rst_carry", carry, 0);
        chk("rst_zero", zero, 0);
        chk("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_rdy = 1'b1;
        chk("idle_in_ready", in_ready, 1);

        for (int i = 0; i < 14; i++) run_vec(i);

        // Backpressure: result must hold for 5 cycles; in_valid pulses ignored.
        out_ready = 1'b0;
        send(4'd4, 8'h0F, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = (i % 2 == 0);
            op = 4'd0; a = 8'hFF; b = 8'hFF;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        chk("bp_z", last_r.z, 8'hF0);
        chk("bp_valid_cycles", last_vcnt, 6);
        run_vec(10);

        // Reset during BUSY aborts the shift.
        send(4'd8, 8'h01, 8'h07);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        chk_rdy = 1'b0;
        q.delete();
        head_seen = 1'b0;
        head_vcnt = 0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_rdy = 1'b1;
        chk("post_abort_in_ready", in_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        run_vec(5);

        // 16-bit instance: full-width carry out.
        in_valid16 = 1'b1; op16 = 4'd6; a16 = 16'hFFFF; b16 = 16'h0001;
        begin
            int t = 0;
            while (!in_ready16 && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
        end
        chk("w16_in_ready", in_ready16, 1);
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        chk("w16_out_valid", out_valid16, 1);
        chk("w16_z", z16, 16'h0000);
        chk("w16_carry", carry16, 1);
        chk("w16_zero", zero16, 1);
        chk("w16_err", err16, 0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
